// File: rtl/restador_pkg.sv
// Shared types and constants for the restador down-counter control slice.
package restador_pkg;

  typedef enum logic [1:0] {READY, LOAD, PRESS, REPEAT} ctrl_state_t;

  localparam int DEB_CYCLES_BOARD = 500000;
  localparam int DEB_CYCLES_SIM   = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/restador_btn_conditioner.sv
// Raw push-button to clean level plus a one-cycle pulse on each accepted press.
module btn_conditioner
  import restador_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_SIM,
  parameter int CNT_W      = $clog2(DEB_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_d;
  logic [CNT_W-1:0] stable_cnt;

  // NOTE: all state uses <= so every flop samples pre-edge values; blocking
  // assignments here would merge the two synchronizer stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      level_d <= level;
      // Count consecutive samples disagreeing with the accepted level.
      if (sync_q2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        level      <= sync_q2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  assign pulse = level & ~level_d;

endmodule

// File: rtl/restador_ctrl.sv
// Button-to-strobe control FSM for the down-counter datapath: load, decrement,
// hold-to-repeat and zero/underflow policy.
module restador_ctrl
  import restador_pkg::*;
#(
  parameter int N            = 6,
  parameter int DEB_CYCLES   = DEB_CYCLES_SIM,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4,
  parameter bit WRAP         = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_sub,
  input  logic         btn_load,
  input  logic [N-1:0] cur_value,
  output logic         load_o,
  output logic         dec_o,
  output logic         zero_o,
  output logic         underflow_o,
  output logic         busy_o
);

  localparam int CNT_W = $clog2(max3(DEB_CYCLES, REPEAT_DELAY, REPEAT_RATE)) + 1;

  if (REPEAT_RATE < 2) begin : g_rate_check
    $error("restador_ctrl: REPEAT_RATE must be >= 2");
  end

  logic sub_level, sub_pulse;
  logic load_level_unused, load_pulse;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_sub (
    .clk(clk), .rst(rst), .raw(btn_sub), .level(sub_level), .pulse(sub_pulse)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_load (
    .clk(clk), .rst(rst), .raw(btn_load), .level(load_level_unused), .pulse(load_pulse)
  );

  ctrl_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             attempt;
  logic             dec_nxt, uf_nxt;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    attempt   = 1'b0;
    unique case (state)
      READY: begin
        if (load_pulse) begin
          state_nxt = LOAD;
        end else if (sub_pulse) begin
          attempt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = PRESS;
        end
      end
      LOAD: state_nxt = READY;
      PRESS: begin
        if (load_pulse) begin
          state_nxt = LOAD;
        end else if (!sub_level) begin
          state_nxt = READY;
        end else if (cnt >= CNT_W'(REPEAT_DELAY - 1)) begin
          attempt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = REPEAT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      REPEAT: begin
        if (load_pulse) begin
          state_nxt = LOAD;
        end else if (!sub_level) begin
          state_nxt = READY;
        end else if (cnt >= CNT_W'(REPEAT_RATE - 1)) begin
          attempt = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = READY;
    endcase
    // A refused decrement at zero still reports underflow; wrap mode decrements anyway.
    dec_nxt = attempt & ((cur_value != '0) | WRAP);
    uf_nxt  = attempt & (cur_value == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= READY;
      cnt         <= '0;
      dec_o       <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      dec_o       <= dec_nxt;
      underflow_o <= uf_nxt;
    end
  end

  assign load_o = (state == LOAD);
  assign busy_o = (state == PRESS) || (state == REPEAT);
  assign zero_o = (cur_value == '0);

endmodule
